// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Front-end PC generator and instruction-fetch buffer. Issues sequential
//   word fetches to instruction memory, reserves a queue slot for every
//   accepted request, fills slots from in-order responses, and presents
//   {pc, inst} to decode. A redirect from execute flushes the queue and
//   counts the still-outstanding responses so they can be discarded on return.
//
// Ports
//   i_clk           clock
//   i_reset_n       synchronous reset, active low
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts request
//   imem_req_addr   byte address of the requested word ([1:0] = 0)
//   imem_rsp_valid  response valid, in request order, no backpressure
//   imem_rsp_data   instruction word
//   exec_ld_pc      redirect strobe from execute
//   exec_br_pc      redirect target
//   i_stall         downstream cannot accept this cycle
//   f_valid         f_pc/f_inst hold a fetched instruction
//   f_pc            PC of presented instruction
//   f_inst          presented instruction word
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        exec_ld_pc,
  input  logic [31:0] exec_br_pc,
  input  logic        i_stall,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_inst
);

  localparam int IW = $clog2(DEPTH);  // slot index width
  localparam int PW = IW + 1;         // pointer width incl. wrap bit

  typedef struct packed {
    logic        alloc;
    logic        filled;
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  slot_t         slots [DEPTH];
  logic [31:0]   pc;
  logic [PW-1:0] head;      // next slot to present
  logic [PW-1:0] tail;      // next slot to allocate
  logic [PW-1:0] fill;      // next slot awaiting a response
  // Stale responses still owed by memory after redirects. Back-to-back
  // redirects add up; the memory is expected to drain them before the
  // count exceeds the pointer range.
  logic [PW-1:0] drop_cnt;

  logic          full;
  logic          issue;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          pop;
  logic [PW-1:0] unfilled;
  logic [PW-1:0] drop_next;
  slot_t         head_slot;

  // Same index with different wrap bits means every slot is reserved.
  assign full = (head[IW] != tail[IW]) && (head[IW-1:0] == tail[IW-1:0]);

  // Slots are allocated and filled in order, so the allocated-but-unfilled
  // slots are exactly those between fill and tail.
  assign unfilled = tail - fill;

  // Depends only on state and reset/redirect, never on imem_rsp_*.
  assign imem_req_valid = i_reset_n && !full && !exec_ld_pc;
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  // A response with nothing to fill and nothing to drop is ignored.
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (fill != tail);

  // A response arriving in the redirect cycle settles one of the debts
  // being transferred into drop_cnt (either an old drop or an unfilled slot).
  assign drop_next = drop_cnt + unfilled - PW'(rsp_drop || rsp_fill);

  assign head_slot = slots[head[IW-1:0]];
  assign f_valid   = head_slot.alloc && head_slot.filled;
  assign f_pc      = head_slot.pc;
  assign f_inst    = head_slot.inst;

  assign pop = f_valid && !i_stall && !exec_ld_pc;

  // NOTE: all state here is updated with non-blocking assignments so every
  // read in this block sees the pre-edge value, regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      drop_cnt <= '0;
      // NOTE: the slot array is reset in full because f_pc/f_inst are read
      // straight from it and must be zero out of reset; it is only DEPTH
      // entries of flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (exec_ld_pc) begin
      pc       <= exec_br_pc;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      drop_cnt <= drop_next;
      // pc/inst are left in place so the don't-care outputs stay stable.
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].alloc  <= 1'b0;
        slots[i].filled <= 1'b0;
      end
    end else begin
      if (issue) begin
        slots[tail[IW-1:0]].alloc  <= 1'b1;
        slots[tail[IW-1:0]].filled <= 1'b0;
        slots[tail[IW-1:0]].pc     <= pc;
        tail <= tail + PW'(1);
        pc   <= pc + 32'd4;
      end

      if (rsp_drop) begin
        drop_cnt <= drop_cnt - PW'(1);
      end

      // fill != tail here, so this never touches the slot being allocated.
      if (rsp_fill) begin
        slots[fill[IW-1:0]].inst   <= imem_rsp_data;
        slots[fill[IW-1:0]].filled <= 1'b1;
        fill <= fill + PW'(1);
      end

      // The popped slot is filled, so it is distinct from tail and fill slots.
      if (pop) begin
        slots[head[IW-1:0]].alloc  <= 1'b0;
        slots[head[IW-1:0]].filled <= 1'b0;
        head <= head + PW'(1);
      end
    end
  end

endmodule
